key_encoder8_3: RTL
===================

KEY_ENCODER8_3 -- requirements
Module: key_encoder8_3

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the stability window in clk cycles; legal range 2..1024.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, with asynchronous assertion and active-low polarity.
REQ-004 The block SHALL have port en, input, 1, the active-high block enable.
REQ-005 The block SHALL have port d, input, 8, the raw active-high key/request lines (asynchronous to clk, bouncy).
REQ-006 The block SHALL have port code, output, 3, the index of the highest-numbered active line in the committed vector.
REQ-007 The block SHALL have port any_key, output, 1, high while the committed vector is nonzero.
REQ-008 The block SHALL have port strobe, output, 1, a one-cycle pulse when a new nonzero code is committed.

Function
REQ-009 The block SHALL pass d through a 2-flop synchronizer per bit; all further logic SHALL use the synchronized vector s.
REQ-010 The FSM SHALL have the states IDLE, SETTLE and HELD, and SHALL hold a committed vector cv plus a counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-011 In IDLE (cv=0), s!=0 SHALL cause entry to SETTLE with cnt=0.
REQ-012 In SETTLE, if s differs from its previous-cycle value, cnt SHALL return to 0.
REQ-013 In SETTLE, if s is unchanged, cnt SHALL increment; when cnt==DEBOUNCE_CYCLES-1 with s unchanged, the block SHALL commit cv<=s.
REQ-014 When the committed s==0, the FSM SHALL go to IDLE, with any_key<=0 and code<=0.
REQ-015 When the committed s!=0, the FSM SHALL go to HELD, with any_key<=1 and code<=prio(s).
REQ-016 In HELD, s!=cv SHALL cause entry to SETTLE with cnt=0; code and any_key SHALL hold their values until the next commit.
REQ-017 SETTLE returning to cv's own value SHALL still require a full window to commit.
REQ-018 prio(v) SHALL be the index of the highest set bit (bit 7 highest priority); prio(0) is unused.
REQ-019 strobe SHALL be 1 for exactly one cycle, coincident with the code update, when a nonzero commit occurs and either the prior any_key was 0 or the new code differs from the old.
REQ-020 strobe SHALL stay 0 on release commits and on commits that leave code unchanged.
REQ-021 Outputs SHALL be registered, and latency SHALL be fixed: a clean d change stable from edge k yields updated code/strobe visible after edge k+DEBOUNCE_CYCLES+3.
REQ-022 When en=0, the block SHALL force state IDLE, cnt=0, cv=0, code=0, any_key=0 and strobe=0 on the next edge; the synchronizer SHALL keep running.
REQ-023 When en rises with keys already held, the block SHALL debounce them from IDLE normally, with strobe firing on commit.
REQ-024 Simultaneous multiple keys SHALL be encoded by priority only; no error flag SHALL be raised.
REQ-025 cnt SHALL saturate at DEBOUNCE_CYCLES-1 and never wrap.

Reset
REQ-026 While rst_n=0, all flops SHALL be cleared asynchronously: synchronizer=0, state=IDLE, cnt=0, cv=0, code=3'b000, any_key=0, strobe=0.
REQ-027 Reset deassertion SHALL be synchronized internally; first state evaluation SHALL occur on the second clk edge after rst_n rises.
REQ-028 Reset mid-SETTLE or mid-HELD SHALL discard all progress, and no strobe SHALL fire from the aborted window.

Structure
REQ-029 Package enc_pkg SHALL contain the FSM state enum (IDLE, SETTLE, HELD) and the constant DEBOUNCE_CYCLES_DEFAULT=16.
REQ-030 The priority function SHALL be a combinational sub-module prio_enc8_3 (8-bit in, 3-bit out); it is the counterpart of the team's 3-to-8 decoder.
REQ-031 The synchronizer SHALL be inline; no other sub-modules SHALL be used.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 d=8'h04 clean from edge 10 -> strobe=1 for one cycle after edge 17; code=3'd2; any_key=1.
REQ-033 d toggling 8'h00/8'h20 every 2 cycles for 20 cycles, then steady 8'h20 -> no strobe during bounce; one strobe with code=5 exactly 7 edges after the last toggle.
REQ-034 Held 8'h04, then d=8'h84 -> strobe, code=7. Then d=8'h80 -> commit with code=7 unchanged and no strobe. Then d=0 -> any_key=0, code=0, no strobe.
REQ-035 Held 8'h01 (code 0, any_key 1), then en=0 for 1 cycle -> code=0, any_key=0. Then en=1 with key held -> strobe again after the full window.
REQ-036 rst_n pulsed low during SETTLE with d=8'h10 -> outputs 0 immediately and no strobe; after release, strobe with code=4 once the debounce completes.
REQ-037 All 8 one-hot values and 8'hFF -> code equals the highest set index for each; 8'hFF gives 7.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg: FSM state encoding and default debounce window for the key encoder.
package enc_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
endpackage

// File: rtl/prio_enc8_3.sv
// prio_enc8_3: index of the highest set bit of an 8-bit vector (0 when empty).
module prio_enc8_3 (
  input  logic [7:0] v,
  output logic [2:0] y
);
  always_comb
    y = v[7] ? 3'd7 : v[6] ? 3'd6 : v[5] ? 3'd5 : v[4] ? 3'd4 :
        v[3] ? 3'd3 : v[2] ? 3'd2 : v[1] ? 3'd1 : 3'd0;
endmodule

// File: rtl/key_encoder8_3.sv
// key_encoder8_3: synchronizes and debounces 8 key lines, then reports the
// highest-priority held key with a one-cycle strobe on each new code.
module key_encoder8_3 import enc_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  output logic [2:0] code,
  output logic       any_key,
  output logic       strobe
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [7:0] sync1, s, s_prev, cv, cv_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] pc, code_n;
  logic run, cm, cm_n, any_n, strobe_n;
  state_t state, state_n;
  prio_enc8_3 u_prio (.v(cv), .y(pc));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cv_n = cv;
    cm_n = 1'b0;
    case (state)
      IDLE: if (s != '0) begin
        state_n = SETTLE;
        cnt_n = '0;
      end
      SETTLE: if (s != s_prev) cnt_n = '0;
      else if (cnt == LAST) begin
        cv_n = s;
        cm_n = 1'b1;
        cnt_n = '0;
        state_n = (s == '0) ? IDLE : HELD;
      end else cnt_n = cnt + 1'b1;
      HELD: if (s != cv) begin
        state_n = SETTLE;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
    if (!en) begin
      state_n = IDLE;
      cnt_n = '0;
      cv_n = '0;
      cm_n = 1'b0;
    end
  end
  // outputs follow the commit by one cycle so code and strobe move together
  always_comb begin
    code_n = !en ? 3'd0 : cm ? pc : code;
    any_n = en && (cm ? |cv : any_key);
    strobe_n = en && cm && |cv && (!any_key || pc != code);
  end
  // run holds the FSM for one edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      s <= '0;
      s_prev <= '0;
      run <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      cv <= '0;
      cm <= 1'b0;
      code <= 3'd0;
      any_key <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync1 <= d;
      s <= sync1;
      s_prev <= s;
      run <= 1'b1;
      if (run) begin
        state <= state_n;
        cnt <= cnt_n;
        cv <= cv_n;
        cm <= cm_n;
        code <= code_n;
        any_key <= any_n;
        strobe <= strobe_n;
      end
    end
endmodule
